// File: rtl/seg7_scan_driver_if.sv
// Load/ack handshake bundle between the value producer and seg7_scan_driver.
// The producer owns value_in/dp_in/load; the display driver answers with load_ack.
interface seg7_scan_driver_if;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        load_ack;

  modport master (
    output value_in,
    output dp_in,
    output load,
    input  load_ack
  );

  modport slave (
    input  value_in,
    input  dp_in,
    input  load,
    output load_ack
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit time-multiplexed driver for a common-anode 7-segment display, with blanking gaps.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
module seg7_scan_driver #(
  parameter int BLANK_CYCLES = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                refresh_in,
  seg7_scan_driver_if.slave   ld,
  output logic                frame_start,
  output logic [1:0]          digit_idx,
  output logic [3:0]          an,
  output logic [6:0]          seg,
  output logic                dp,
  output logic                dbg_state
);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYCLES - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // refresh_in is asynchronous data: synchronize, then register a rising-edge pulse.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   scan_tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= '0;
      edge_q    <= 1'b0;
      scan_tick <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], refresh_in};
      edge_q    <= sync_q[SYNC_STAGES-1];
      scan_tick <= sync_q[SYNC_STAGES-1] & ~edge_q;
    end
  end

  state_t      state, state_d;
  logic [7:0]  blank_cnt, blank_cnt_d;
  logic [1:0]  idx_d;
  logic [15:0] shadow_val, shadow_val_d;
  logic [3:0]  shadow_dp, shadow_dp_d;
  logic [15:0] pend_val, pend_val_d;
  logic [3:0]  pend_dp, pend_dp_d;
  logic        pending, pending_d;
  logic        frame_start_d, load_ack_d;
  logic [3:0]  an_d;
  logic [6:0]  seg_d;
  logic        dp_d;
  logic [3:0]  nibble_d;
  logic        lz_blank;

  // Handshake: a one-cycle load captures value_in/dp_in into the pending registers
  // (a later load before commit overwrites them). At the next frame boundary the
  // pending value moves to the shadow and load_ack pulses once for that commit;
  // a load landing in the commit cycle itself stays pending for the following frame.
  always_comb begin
    state_d       = state;
    blank_cnt_d   = blank_cnt;
    idx_d         = digit_idx;
    shadow_val_d  = shadow_val;
    shadow_dp_d   = shadow_dp;
    pend_val_d    = pend_val;
    pend_dp_d     = pend_dp;
    pending_d     = pending;
    frame_start_d = 1'b0;
    load_ack_d    = 1'b0;

    case (state)
      ST_BLANK: begin
        if (blank_cnt == BLANK_LAST) begin
          blank_cnt_d = 8'd0;
          state_d     = ST_SHOW;
          if (digit_idx == 2'd0) begin
            frame_start_d = 1'b1;
            if (pending) begin
              shadow_val_d = pend_val;
              shadow_dp_d  = pend_dp;
              load_ack_d   = 1'b1;
              pending_d    = 1'b0;
            end
          end
        end else begin
          blank_cnt_d = blank_cnt + 8'd1;
        end
      end
      ST_SHOW: begin
        if (scan_tick) begin
          state_d = ST_BLANK;
          idx_d   = digit_idx + 2'd1;
        end
      end
      default: state_d = ST_BLANK;
    endcase

    if (ld.load) begin
      pend_val_d = ld.value_in;
      pend_dp_d  = ld.dp_in;
      pending_d  = 1'b1;
    end

    // Outputs are computed from next-state values so they change with the state.
    nibble_d = shadow_val_d[{idx_d, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    lz_blank = (idx_d != 2'd0) &&
               ((shadow_val_d >> {idx_d, 2'b00}) == 16'h0000) &&
               !shadow_dp_d[idx_d];
`else
    lz_blank = 1'b0;
`endif

    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (state_d == ST_SHOW) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = lz_blank ? 7'h7F : hex_to_seg(nibble_d);
      dp_d  = ~shadow_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_BLANK;
      blank_cnt   <= 8'd0;
      digit_idx   <= 2'd0;
      shadow_val  <= 16'h0000;
      shadow_dp   <= 4'h0;
      pend_val    <= 16'h0000;
      pend_dp     <= 4'h0;
      pending     <= 1'b0;
      frame_start <= 1'b0;
      ld.load_ack <= 1'b0;
      an          <= 4'hF;
      seg         <= 7'h7F;
      dp          <= 1'b1;
    end else begin
      state       <= state_d;
      blank_cnt   <= blank_cnt_d;
      digit_idx   <= idx_d;
      shadow_val  <= shadow_val_d;
      shadow_dp   <= shadow_dp_d;
      pend_val    <= pend_val_d;
      pend_dp     <= pend_dp_d;
      pending     <= pending_d;
      frame_start <= frame_start_d;
      ld.load_ack <= load_ack_d;
      an          <= an_d;
      seg         <= seg_d;
      dp          <= dp_d;
    end
  end

  assign dbg_state = state;

endmodule
